// File: rtl/supercar_pkg.sv
// -----------------------------------------------------------------------------
// supercar_pkg
//   Shared definitions for the supercar LED scanner:
//     - state_t : scanner FSM state encoding
//     - mode_t  : scan mode selector and its four named values
// -----------------------------------------------------------------------------
package supercar_pkg;

   // Scanner FSM states. IDLE is left only once the scanner is first enabled.
   // The HOLD_x states pause at an end of the bar in bounce mode.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN_UP   = 3'd1,
      RUN_DOWN = 3'd2,
      HOLD_TOP = 3'd3,
      HOLD_BOT = 3'd4
   } state_t;

   // Scan mode selector.
   typedef logic [1:0] mode_t;

   localparam mode_t MODE_BOUNCE = 2'b00;  // sweep up and down, pause at ends
   localparam mode_t MODE_UP     = 2'b01;  // rotate toward MSB, wrap to 0
   localparam mode_t MODE_DOWN   = 2'b10;  // rotate toward LSB, wrap to top
   localparam mode_t MODE_HOLD   = 2'b11;  // ignore steps, freeze position

endpackage : supercar_pkg

// File: rtl/supercar_ctrl.sv
// -----------------------------------------------------------------------------
// supercar_ctrl
//   "Knight Rider" style LED scanner. One lit LED moves by one position on
//   every step tick (p_e) from an external prescaler. In bounce mode the light
//   sweeps up and down and pauses END_HOLD ticks at each end; in the rotate
//   modes it wraps around; in hold mode it stays put.
//
// Parameters
//   N_LED    : number of LEDs scanned (2..32)
//   END_HOLD : step ticks spent at each end in bounce mode (0..15)
//
// Ports
//   clk    in  : clock, all state changes on the rising edge
//   rst    in  : asynchronous reset, active low
//   en     in  : run enable; 0 freezes all state and drops p_e
//   p_e    in  : one-cycle step tick from the prescaler
//   mode   in  : 00 bounce, 01 rotate-up, 10 rotate-down, 11 hold
//   pre_en out : enable for the prescaler, high only while scanning
//   led    out : one-hot LED pattern, bit pos lit
//   dir    out : current direction, 0 = toward MSB, 1 = toward LSB
//   wrap   out : one-cycle pulse after a step that lands on either end
// -----------------------------------------------------------------------------
module supercar_ctrl
   import supercar_pkg::*;
#(
   parameter int N_LED    = 8,
   parameter int END_HOLD = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             p_e,
   input  logic [1:0]       mode,
   output logic             pre_en,
   output logic [N_LED-1:0] led,
   output logic             dir,
   output logic             wrap
);

   // Position and hold counter are sized to what they must reach.
   localparam int POS_W  = $clog2(N_LED);
   localparam int HOLD_W = (END_HOLD < 1) ? 1 : $clog2(END_HOLD + 1);

   localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LED - 1);
   localparam logic [N_LED-1:0] LED_ONE = {{(N_LED-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic               dir_q, dir_d;
   logic               wrap_q, wrap_d;
   logic               pre_en_q, pre_en_d;

   logic [POS_W-1:0]   pos_inc;
   logic [POS_W-1:0]   pos_dec;
   logic               hold_last;
   logic               moved;

   assign pos_inc = pos_q + 1'b1;
   assign pos_dec = pos_q - 1'b1;

   // The tick being counted now is the last one of the end pause.
   assign hold_last = (int'(hold_cnt_q) + 1) >= END_HOLD;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every value driven here gets its default first, so no path
      // through the case statements can leave one unassigned and infer a latch.
      state_d    = state_q;
      pos_d      = pos_q;
      hold_cnt_d = hold_cnt_q;
      dir_d      = dir_q;
      moved      = 1'b0;

      if (en) begin
         if (state_q == IDLE) begin
            // Leaving IDLE needs no tick; the first step comes afterwards.
            state_d = RUN_UP;
         end else if (p_e) begin
            unique case (mode)
               MODE_UP: begin
                  state_d    = RUN_UP;
                  dir_d      = 1'b0;
                  hold_cnt_d = '0;
                  // Coming out of an end pause only changes state; the light
                  // does not move on that tick.
                  if (state_q == RUN_UP || state_q == RUN_DOWN) begin
                     pos_d = (pos_q == POS_MAX) ? '0 : pos_inc;
                     moved = 1'b1;
                  end
               end

               MODE_DOWN: begin
                  state_d    = RUN_DOWN;
                  dir_d      = 1'b1;
                  hold_cnt_d = '0;
                  if (state_q == RUN_UP || state_q == RUN_DOWN) begin
                     pos_d = (pos_q == '0) ? POS_MAX : pos_dec;
                     moved = 1'b1;
                  end
               end

               MODE_BOUNCE: begin
                  unique case (state_q)
                     RUN_UP: begin
                        moved = 1'b1;
                        if (pos_q == POS_MAX) begin
                           // Already at the top after a rotate: turn around.
                           pos_d   = pos_dec;
                           state_d = RUN_DOWN;
                           dir_d   = 1'b1;
                        end else begin
                           pos_d = pos_inc;
                           if (pos_inc == POS_MAX) begin
                              if (END_HOLD == 0) begin
                                 state_d = RUN_DOWN;
                                 dir_d   = 1'b1;
                              end else begin
                                 state_d    = HOLD_TOP;
                                 hold_cnt_d = '0;
                              end
                           end
                        end
                     end

                     RUN_DOWN: begin
                        moved = 1'b1;
                        if (pos_q == '0) begin
                           // Already at the bottom after a rotate: turn around.
                           pos_d   = pos_inc;
                           state_d = RUN_UP;
                           dir_d   = 1'b0;
                        end else begin
                           pos_d = pos_dec;
                           if (pos_dec == '0) begin
                              if (END_HOLD == 0) begin
                                 state_d = RUN_UP;
                                 dir_d   = 1'b0;
                              end else begin
                                 state_d    = HOLD_BOT;
                                 hold_cnt_d = '0;
                              end
                           end
                        end
                     end

                     HOLD_TOP: begin
                        if (hold_last) begin
                           state_d    = RUN_DOWN;
                           dir_d      = 1'b1;
                           hold_cnt_d = '0;
                        end else begin
                           hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                     end

                     HOLD_BOT: begin
                        if (hold_last) begin
                           state_d    = RUN_UP;
                           dir_d      = 1'b0;
                           hold_cnt_d = '0;
                        end else begin
                           hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                     end

                     default: ;
                  endcase
               end

               MODE_HOLD: ;  // steps ignored, everything held

               default: ;
            endcase
         end
      end

      wrap_d   = moved && (pos_d == '0 || pos_d == POS_MAX);
      pre_en_d = en && (state_q != IDLE);
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before this edge, independent of statement order.
      if (!rst) begin
         state_q    <= IDLE;
         pos_q      <= '0;
         hold_cnt_q <= '0;
         dir_q      <= 1'b0;
         wrap_q     <= 1'b0;
         pre_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         hold_cnt_q <= hold_cnt_d;
         dir_q      <= dir_d;
         wrap_q     <= wrap_d;
         pre_en_q   <= pre_en_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs; led is a pure decode of pos so it is one-hot by construction.
   // --------------------------------------------------------------------------
   assign led    = LED_ONE << pos_q;
   assign dir    = dir_q;
   assign wrap   = wrap_q;
   assign pre_en = pre_en_q;

endmodule : supercar_ctrl
